gate_truth_sweeper: RTL and testbench
=====================================

// Module: gate_truth_sweeper
// PURPOSE
//  Sequential truth-table driver/checker placed directly around a combinational gate under test (DUT).
//  Drives every input vector onto the DUT, waits for it to settle, then samples the DUT output.
//  Compares each sample against the expected function and streams one result row per vector over a valid/ready port.
//  Reports the pass/fail summary at the end of the sweep.
// PARAMETERS
//  N_IN           2  DUT input count, 1..8; sweep covers 2**N_IN vectors
//  SETTLE_CYCLES  1  cycles dut_in is held before sampling, 1..15
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  start      in   1        pulse to begin sweep; sampled only in IDLE
//  op         in   3        expected fn: 0 AND,1 OR,2 NAND,3 NOR,4 XOR,5 XNOR,6 NOT(dut_in[0]),7 rsvd=OR
//  dut_in     out  N_IN     vector driven to the DUT
//  dut_out    in   1        DUT result
//  row_valid  out  1        result row available
//  row_ready  in   1        consumer accepts the row
//  row_vec    out  N_IN     vector of the current row
//  row_out    out  1        sampled dut_out
//  row_exp    out  1        expected value
//  busy       out  1        high in every state except IDLE
//  done       out  1        one-cycle pulse at end of sweep
//  pass       out  1        err_count==0 at last done; held until next start
//  err_count  out  N_IN+1   mismatches this sweep
//  fail_vec   out  N_IN     first mismatching vector; 0 if none
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; vector counter 0; latched op = 1 (OR).
//   - Reset acts immediately, including mid-sweep.
//   - A sweep interrupted by reset is abandoned and produces no done.
//  FSM states: IDLE, DRIVE, SAMPLE, EMIT, DONE.
//   - IDLE: on start=1, latch op; clear vec, err_count, fail_vec and pass; go to DRIVE.
//   - DRIVE: dut_in=vec; stay for exactly SETTLE_CYCLES cycles; then go to SAMPLE.
//   - SAMPLE: one cycle. Capture dut_out into row_out; compute row_exp from the latched op over dut_in.
//     On mismatch, err_count+1; on the first mismatch only, fail_vec=vec. Then go to EMIT.
//   - EMIT: row_valid=1; row_vec, row_out and row_exp held stable until row_ready=1.
//     On handshake: if vec==2**N_IN-1 go to DONE; else vec+1 and go to DRIVE.
//   - DONE: done=1 and pass=(err_count==0) for one cycle; then go to IDLE.
//  dut_in holds its last vector through SAMPLE, EMIT, DONE and IDLE; it returns to 0 only at the next start or reset.
//  row_valid is 0 outside EMIT. No row is dropped, and no row is duplicated.
//  start while busy is ignored. start asserted during the DONE cycle is also ignored.
//  op changes mid-sweep have no effect (the latched value is used).
//  Throughput: SETTLE_CYCLES+2 cycles per row with row_ready held at 1.
//  err_count max is 2**N_IN and fits N_IN+1 bits without saturation.
//  The vector counter never wraps: the terminal vector exits to DONE.
// CONFIGURATION
//  STOP_ON_FAIL_EN defined:
//   - On the first mismatch, the row is still emitted.
//   - After its handshake the FSM goes to DONE (pass=0, err_count=1) instead of advancing.
//  STOP_ON_FAIL_EN undefined: full sweep always; err_count counts all mismatches.
// TESTING
//  1. N_IN=2, SETTLE=1, op=1, DUT=ideal OR, row_ready=1, start pulse ->
//     rows (vec/out/exp) 00/0/0, 01/1/1, 10/1/1, 11/1/1.
//     done 12 cycles after the start edge; pass=1; err_count=0.
//  2. op=0 with an OR DUT -> mismatches at vec 01 and 10; err_count=2; fail_vec=01; pass=0.
//  3. row_ready held 0 for 5 cycles at row vec=10 -> row_valid and row data stable throughout; dut_in stays 10;
//     the sweep resumes on ready and done is 5 cycles later than in test 1.
//  4. rst_n low during the DRIVE of vec=10 -> all outputs 0 asynchronously; no done;
//     the next start gives a clean sweep matching test 1.
//  5. start re-pulsed while busy, and op changed mid-sweep -> ignored; results identical to test 1.
//  6. STOP_ON_FAIL_EN, op=0, OR DUT -> rows 00 and 01 emitted, then done; err_count=1; fail_vec=01.
//     Without the macro, same stimulus gives the test-2 results.

Source files
------------

// File: rtl/gate_truth_sweeper.sv
// rtl/gate_truth_sweeper.sv - truth-table sweep driver/checker around a combinational gate; optional STOP_ON_FAIL_EN
module gate_truth_sweeper #(
    parameter int N_IN          = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            row_valid,
    input  logic            row_ready,
    output logic [N_IN-1:0] row_vec,
    output logic            row_out,
    output logic            row_exp,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic [N_IN-1:0] fail_vec
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SAMPLE = 3'd2,
        EMIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [N_IN-1:0] vec;
    logic [3:0]      settle_cnt;
    logic [2:0]      op_q;
    logic            exp_bit;
    logic            last_vec;
    logic            stop_now;

    // The vector register is what the gate sees; it only moves at start, handshake or reset.
    assign dut_in   = vec;
    assign row_vec  = vec;
    assign last_vec = (vec == {N_IN{1'b1}});

`ifdef STOP_ON_FAIL_EN
    // Any error recorded so far can only be the row being emitted, since we stop on the first.
    assign stop_now = (err_count != '0);
`else
    assign stop_now = 1'b0;
`endif

    // Expected gate response for the latched operation over the current vector.
    always_comb begin
        exp_bit = 1'b0;
        case (op_q)
            3'd0:    exp_bit = &vec;
            3'd1:    exp_bit = |vec;
            3'd2:    exp_bit = ~(&vec);
            3'd3:    exp_bit = ~(|vec);
            3'd4:    exp_bit = ^vec;
            3'd5:    exp_bit = ~(^vec);
            3'd6:    exp_bit = ~vec[0];
            default: exp_bit = |vec;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and status outputs decoded from the current state.
    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        row_valid = (state == EMIT);
        case (state)
            IDLE:    if (start) state_nx = DRIVE;
            DRIVE:   if (settle_cnt == 4'(SETTLE_CYCLES - 1)) state_nx = SAMPLE;
            SAMPLE:  state_nx = EMIT;
            EMIT:    if (row_ready) state_nx = (last_vec || stop_now) ? DONE : DRIVE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Sweep datapath: vector stepping, settle timing, sampling and error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '0;
            settle_cnt <= '0;
            op_q       <= 3'd1;
            row_out    <= 1'b0;
            row_exp    <= 1'b0;
            err_count  <= '0;
            fail_vec   <= '0;
            pass       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q       <= op;
                        vec        <= '0;
                        settle_cnt <= '0;
                        err_count  <= '0;
                        fail_vec   <= '0;
                        pass       <= 1'b0;
                    end
                end
                DRIVE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                end
                SAMPLE: begin
                    row_out <= dut_out;
                    row_exp <= exp_bit;
                    if (dut_out != exp_bit) begin
                        err_count <= err_count + (N_IN+1)'(1);
                        if (err_count == '0) begin
                            fail_vec <= vec;
                        end
                    end
                end
                EMIT: begin
                    if (row_ready) begin
                        settle_cnt <= '0;
                        if (last_vec || stop_now) begin
                            pass <= (err_count == '0);
                        end else begin
                            vec <= vec + N_IN'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_sweeper.sv
// tb/tb_gate_truth_sweeper.sv - scoreboard bench for gate_truth_sweeper with a behavioural gate and sweep model
module tb_gate_truth_sweeper;

    localparam int N  = 2;
    localparam int S  = 1;
    localparam int NV = 1 << N;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [N-1:0] dut_in;
    logic         dut_out;
    logic         row_valid;
    logic         row_ready = 1'b1;
    logic [N-1:0] row_vec;
    logic         row_out;
    logic         row_exp;
    logic         busy;
    logic         done;
    logic         pass;
    logic [N:0]   err_count;
    logic [N-1:0] fail_vec;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_edge = 0;
    int gate_op = 1;
    logic [NV-1:0] fault = '0;
    int stall_plan [NV];

    typedef struct {int vec; bit out; bit exp;} row_t;
    typedef struct {int err; int fvec; bit pass; int lat;} sum_t;
    row_t row_q[$];
    sum_t sum_q[$];

    gate_truth_sweeper #(.N_IN(N), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .dut_in(dut_in), .dut_out(dut_out),
        .row_valid(row_valid), .row_ready(row_ready),
        .row_vec(row_vec), .row_out(row_out), .row_exp(row_exp),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_vec(fail_vec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Gate truth defined by how many inputs are high, not by bitwise operators.
    function automatic bit ref_fn(input int o, input int v);
        int ones;
        ones = $countones(v);
        case (o)
            0:       return ones == N;
            1:       return ones != 0;
            2:       return ones != N;
            3:       return ones == 0;
            4:       return (ones % 2) == 1;
            5:       return (ones % 2) == 0;
            6:       return (v % 2) == 0;
            default: return ones != 0;
        endcase
    endfunction

    assign dut_out = ref_fn(gate_op, int'(dut_in)) ^ fault[dut_in];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk_reset_outs(input string name);
        chk(name, {dut_in, row_valid, row_vec, row_out, row_exp, busy, done, pass, err_count, fail_vec}, 0);
    endtask

    // Build the expected rows and summary for one sweep from the truth-table rules.
    task automatic prep(input int o, input int g, input logic [NV-1:0] f, input int stall_mode);
        int errs;
        int fv;
        int lat;
        bit out_b;
        bit exp_b;
        errs = 0; fv = 0; lat = 0;
        gate_op = g;
        fault = f;
        for (int v = 0; v < NV; v++) begin
            stall_plan[v] = (stall_mode == 1) ? int'($urandom_range(0, 3)) :
                            (stall_mode == 2 && v == 2) ? 5 : 0;
        end
        for (int v = 0; v < NV; v++) begin
            out_b = ref_fn(g, v) ^ f[v];
            exp_b = ref_fn(o, v);
            row_q.push_back('{v, out_b, exp_b});
            lat += S + 2 + stall_plan[v];
            if (out_b != exp_b) begin
                if (errs == 0) fv = v;
                errs++;
`ifdef STOP_ON_FAIL_EN
                break;
`endif
            end
        end
        sum_q.push_back('{errs, fv, errs == 0, lat});
    endtask

    task automatic pulse(input int o);
        @(negedge clk);
        op = 3'(o);
        start = 1'b1;
        start_edge = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sweep(input int o, input int g, input logic [NV-1:0] f, input bit disturb, input int stall_mode);
        int n;
        bit exp_pass;
        n = 0;
        while (busy && n < 500) begin @(negedge clk); n++; end
        if (busy) chk("idle_timeout", 1, 0);
        prep(o, g, f, stall_mode);
        exp_pass = sum_q[sum_q.size()-1].pass;
        pulse(o);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (disturb) begin
                start = 1'($urandom_range(0, 1));
                op = 3'($urandom_range(0, 7));
            end
        end while (busy && n < 1000);
        start = 1'b0;
        if (busy) begin
            chk("sweep_timeout", 1, 0);
            row_q.delete();
            sum_q.delete();
        end
        chk("pass_hold", pass, exp_pass);
    endtask

    // Monitor: compares every presented row and every done against the scoreboard, and plays the consumer.
    initial begin : monitor
        int   stalls;
        sum_t s;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                row_ready = 1'b1;
                stalls = 0;
                continue;
            end
            if (row_valid) begin
                if (row_q.size() == 0) begin
                    chk("row_unexpected", 1, 0);
                    row_ready = 1'b1;
                end else begin
                    chk("row_vec", row_vec, row_q[0].vec);
                    chk("row_out", row_out, row_q[0].out);
                    chk("row_exp", row_exp, row_q[0].exp);
                    chk("dut_in_hold", dut_in, row_q[0].vec);
                    if (stalls < stall_plan[row_q[0].vec]) begin
                        row_ready = 1'b0;
                        stalls++;
                    end else begin
                        row_ready = 1'b1;
                        stalls = 0;
                        void'(row_q.pop_front());
                    end
                end
            end else begin
                row_ready = 1'b1;
            end
            if (done) begin
                if (sum_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    s = sum_q.pop_front();
                    chk("err_count", err_count, s.err);
                    chk("fail_vec", fail_vec, s.fvec);
                    chk("pass", pass, s.pass);
                    chk("done_latency", cyc - start_edge, s.lat);
                    chk("rows_left", row_q.size(), 0);
                end
            end
        end
    end

    initial begin : driver
        int n;
        logic [NV-1:0] f;
        int o;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset_outs");
        rst_n = 1'b1;

        sweep(1, 1, '0, 1'b0, 0);
        sweep(0, 1, '0, 1'b0, 0);
        sweep(1, 1, '0, 1'b0, 2);

        prep(1, 1, '0, 0);
        pulse(1);
        n = 0;
        while (dut_in != 2'd2 && n < 200) begin @(negedge clk); n++; end
        chk("reach_vec2", dut_in, 2);
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("midsweep_reset");
        row_q.delete();
        sum_q.delete();
        repeat (2) @(negedge clk);
        chk_reset_outs("reset_hold");
        rst_n = 1'b1;
        sweep(1, 1, '0, 1'b0, 0);

        sweep(1, 1, '0, 1'b1, 0);

        repeat (24) begin
            o = int'($urandom_range(0, 7));
            f = ($urandom_range(0, 1) == 1) ? NV'($urandom) : '0;
            sweep(o, ($urandom_range(0, 1) == 1) ? o : int'($urandom_range(0, 7)), f,
                  1'($urandom_range(0, 1)), 1);
        end

        repeat (4) @(negedge clk);
        chk("queues_drained", row_q.size() + sum_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
